// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
//
// Instruction-memory responder sitting on the far side of the fetch
// interface. The fetch unit sends PC-addressed requests over a valid/ready
// handshake. The responder reads a 32-bit word from an internal
// word-addressed array. It then returns responses strictly in order, after a
// programmable latency, through a small outstanding-request queue.
//
// Ports:
//   sys_clk     clock; all state updates on the rising edge
//   sys_rst     asynchronous active-low reset
//   req_valid   fetch request present
//   req_ready   a request can be accepted this cycle
//   req_addr    fetch byte address (PC)
//   flush       discard all outstanding requests/responses (redirect)
//   resp_valid  head response available
//   resp_ready  initiator consumes the head response
//   resp_inst   instruction word (NOP when resp_err)
//   resp_addr   address of the request being answered
//   resp_err    request was misaligned or outside the array
//   wr_en       preload write strobe
//   wr_addr     word index to write
//   wr_data     word to write
// ---------------------------------------------------------------------------
module imem_responder #(
    parameter int unsigned       ADDR_W     = 64,
    parameter int unsigned       DEPTH_LOG2 = 10,
    parameter int unsigned       LATENCY    = 2,
    parameter int unsigned       QDEPTH     = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 64'h0000_0000_8000_0000
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic                  flush,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_inst,
    output logic [ADDR_W-1:0]     resp_addr,
    output logic                  resp_err,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [31:0]           wr_data
);

    localparam int unsigned       PTR_W       = $clog2(QDEPTH);
    localparam int unsigned       CD_W        = 4;
    localparam int unsigned       WORDS       = 2 ** DEPTH_LOG2;
    localparam logic [ADDR_W-1:0] ARRAY_BYTES = ADDR_W'(64'd4 << DEPTH_LOG2);
    localparam logic [31:0]       NOP_INST    = 32'h0000_0013;
    localparam logic [CD_W-1:0]   CD_LOAD     = CD_W'(LATENCY - 1);
    localparam logic [PTR_W:0]    COUNT_FULL  = (PTR_W + 1)'(QDEPTH);

    // Program storage; deliberately outside the reset domain.
    logic [31:0] mem [WORDS];

    // Outstanding-request queue, one slot per entry.
    logic [ADDR_W-1:0] q_addr [QDEPTH];
    logic              q_err  [QDEPTH];
    logic [31:0]       q_inst [QDEPTH];
    logic [CD_W-1:0]   q_cd   [QDEPTH];

    logic [PTR_W:0]    count;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    // Low during reset and for the first edge after release, so req_ready
    // never depends combinationally on the reset pin.
    logic              alive;

    logic              accept;
    logic              pop;

    // Request decode.
    logic [ADDR_W-1:0]     req_off;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  req_err;
    logic [31:0]           req_word;

    // -----------------------------------------------------------------------
    // Handshake and request decode
    // -----------------------------------------------------------------------
    always_comb begin
        req_ready = alive && (count < COUNT_FULL) && !flush;
        accept    = req_valid && req_ready;
    end

    always_comb begin
        // Unsigned wrap makes addresses below BASE_ADDR look huge, so the
        // single range compare also catches them.
        req_off  = req_addr - BASE_ADDR;
        req_idx  = req_off[DEPTH_LOG2+1:2];
        req_err  = (req_addr[1:0] != 2'b00) || (req_off >= ARRAY_BYTES);
        req_word = req_err ? NOP_INST : mem[req_idx];
    end

    // -----------------------------------------------------------------------
    // Response presentation
    // -----------------------------------------------------------------------
    always_comb begin
        resp_valid = (count != '0) && (q_cd[rd_ptr] == '0);
        resp_inst  = '0;
        resp_addr  = '0;
        resp_err   = 1'b0;
        if (resp_valid) begin
            resp_inst = q_inst[rd_ptr];
            resp_addr = q_addr[rd_ptr];
            resp_err  = q_err[rd_ptr];
        end
        pop = resp_valid && resp_ready;
    end

    // -----------------------------------------------------------------------
    // Program array write port. The accept path reads mem in the same edge
    // through non-blocking semantics, which gives read-before-write.
    // -----------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // -----------------------------------------------------------------------
    // Queue state
    // -----------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            alive  <= 1'b0;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                q_addr[PTR_W'(i)] <= '0;
                q_err[PTR_W'(i)]  <= 1'b0;
                q_inst[PTR_W'(i)] <= '0;
                q_cd[PTR_W'(i)]   <= '0;
            end
        end else begin
            alive <= 1'b1;

            // Countdowns tick on every slot. Stale slots are harmless
            // because a slot is always reloaded when it is refilled.
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                if (q_cd[PTR_W'(i)] != '0) begin
                    q_cd[PTR_W'(i)] <= q_cd[PTR_W'(i)] - CD_W'(1);
                end
            end

            if (flush) begin
                // req_ready is low here, so no accept can collide with it.
                // A pop in this cycle simply disappears with the rest.
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (accept) begin
                    q_addr[wr_ptr] <= req_addr;
                    q_err[wr_ptr]  <= req_err;
                    q_inst[wr_ptr] <= req_word;
                    q_cd[wr_ptr]   <= CD_LOAD;
                    wr_ptr         <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({accept, pop})
                    2'b10:   count <= count + (PTR_W + 1)'(1);
                    2'b01:   count <= count - (PTR_W + 1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// ---------------------------------------------------------------------------
// tb_imem_responder
//
// Self-checking bench for imem_responder. A reference model tracks the
// outstanding requests as a queue of expected responses. Each entry carries
// the cycle it was accepted in, so that visibility timing is derived from
// the latency rule. The program array is mirrored in a plain array. The
// monitor compares every DUT output on each falling edge.
// ---------------------------------------------------------------------------
module tb_imem_responder;

    localparam int unsigned ADDR_W     = 64;
    localparam int unsigned DEPTH_LOG2 = 10;
    localparam int unsigned LATENCY    = 2;
    localparam int unsigned QDEPTH     = 4;
    localparam logic [63:0] BASE       = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic                  sys_clk = 1'b0;
    logic                  sys_rst;
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     req_addr;
    logic                  flush;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_inst;
    logic [ADDR_W-1:0]     resp_addr;
    logic                  resp_err;
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [31:0]           wr_data;

    imem_responder #(
        .ADDR_W     (ADDR_W),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .LATENCY    (LATENCY),
        .QDEPTH     (QDEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_inst  (resp_inst),
        .resp_addr  (resp_addr),
        .resp_err   (resp_err),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    typedef struct {
        logic [63:0] addr;
        logic [31:0] inst;
        logic        err;
        int          acc;   // cycle number in which the request was accepted
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [1024];
    bit          model_alive = 0;
    int          cyc = 0;

    always @(posedge sys_clk) cyc++;

    function automatic exp_t predict(input logic [63:0] a, input int acc_cycle);
        exp_t        e;
        logic [63:0] off;
        off    = a - BASE;
        e.addr = a;
        e.err  = (a % 4 != 0) || (off >= 64'd4096);
        e.inst = e.err ? NOP : model_mem[off / 4];
        e.acc  = acc_cycle;
        return e;
    endfunction

    // Monitor: compare the present outputs, then apply what the next rising
    // edge will do. Inputs only change just after a rising edge.
    always @(negedge sys_clk) begin
        bit   exp_valid;
        bit   exp_ready;
        exp_t h;
        if (!sys_rst) begin
            sb.delete();
            model_alive = 0;
            chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
            chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
            chk("rst_resp_inst", {32'd0, resp_inst}, 64'd0);
        end else begin
            exp_valid = (sb.size() > 0) && (cyc >= sb[0].acc + int'(LATENCY) - 1);
            exp_ready = model_alive && (sb.size() < int'(QDEPTH)) && !flush;
            chk("resp_valid", {63'd0, resp_valid}, {63'd0, exp_valid});
            chk("req_ready", {63'd0, req_ready}, {63'd0, exp_ready});
            if (exp_valid) begin
                h = sb[0];
                chk("resp_inst", {32'd0, resp_inst}, {32'd0, h.inst});
                chk("resp_addr", resp_addr, h.addr);
                chk("resp_err", {63'd0, resp_err}, {63'd0, h.err});
            end else begin
                chk("idle_inst", {32'd0, resp_inst}, 64'd0);
                chk("idle_addr", resp_addr, 64'd0);
                chk("idle_err", {63'd0, resp_err}, 64'd0);
            end
            if (flush) begin
                sb.delete();
            end else begin
                if (exp_valid && resp_ready) void'(sb.pop_front());
                if (req_valid && exp_ready) sb.push_back(predict(req_addr, cyc + 1));
            end
            model_alive = 1;
        end
        if (wr_en) model_mem[wr_addr] = wr_data;
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send(input logic [63:0] a);
        bit got = 0;
        req_valid = 1'b1;
        req_addr  = a;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge sys_clk);
            got = req_ready;
            @(posedge sys_clk);
            #1;
        end
        req_valid = 1'b0;
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL send_timeout: request %h not accepted within 100 cycles", a);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        sys_rst    = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        flush      = 1'b0;
        resp_ready = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        tick(3);
        sys_rst = 1'b1;
        tick(1);

        // Preload the low 64 words; the tests only read from this region.
        for (int i = 0; i < 64; i++) begin
            wr_en   = 1'b1;
            wr_addr = DEPTH_LOG2'(i);
            wr_data = (i == 0) ? 32'h0010_0093 : (i == 5) ? NOP : $urandom;
            tick(1);
        end
        wr_en = 1'b0;

        // Basic fetch with fixed latency.
        resp_ready = 1'b1;
        send(BASE);
        tick(4);

        // Fill the queue with resp_ready low, then drain.
        resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(BASE + 64'(4 * i));
        tick(3);
        resp_ready = 1'b1;
        tick(6);

        // Misaligned, past the end, below the base.
        send(BASE + 64'h2);
        send(BASE + 64'h1000);
        send(64'h0000_0000_7FFF_FFFC);
        tick(5);

        // Flush with responses pending.
        resp_ready = 1'b0;
        send(BASE + 64'h20);
        send(BASE + 64'h24);
        send(BASE + 64'h28);
        tick(1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(3);
        resp_ready = 1'b1;
        send(BASE + 64'h10);
        tick(4);

        // Same-edge write and read of word 5.
        wr_en   = 1'b1;
        wr_addr = DEPTH_LOG2'(5);
        wr_data = 32'hDEAD_BEEF;
        send(BASE + 64'h14);
        wr_en = 1'b0;
        send(BASE + 64'h14);
        tick(4);

        // Asynchronous reset with two entries queued.
        resp_ready = 1'b0;
        send(BASE + 64'h30);
        send(BASE + 64'h34);
        #2;
        sys_rst = 1'b0;
        #1;
        chk("async_rst_valid", {63'd0, resp_valid}, 64'd0);
        chk("async_rst_ready", {63'd0, req_ready}, 64'd0);
        tick(2);
        sys_rst = 1'b1;
        resp_ready = 1'b1;
        tick(6);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r <= 6)      a = BASE + 64'(4 * $urandom_range(0, 63));
            else if (r == 7) a = BASE + 64'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
            else if (r == 8) a = BASE + 64'h1000 + 64'(4 * $urandom_range(0, 100));
            else             a = BASE - 64'(4 * $urandom_range(1, 50));
            req_valid  = ($urandom_range(0, 9) < 7);
            req_addr   = a;
            resp_ready = ($urandom_range(0, 9) < 6);
            flush      = ($urandom_range(0, 99) < 3);
            wr_en      = ($urandom_range(0, 9) < 2);
            wr_addr    = DEPTH_LOG2'($urandom_range(0, 63));
            wr_data    = $urandom;
            tick(1);
        end
        req_valid  = 1'b0;
        flush      = 1'b0;
        wr_en      = 1'b0;
        resp_ready = 1'b1;
        tick(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
